// File: rtl/imm_cu_pkg.sv
// Shared definitions for the immediate-instruction control unit:
// state encodings, opcode and ALU operation constants, small helpers.
package imm_cu_pkg;

  typedef logic [3:0] state_t;

  // FSM state encodings (visible on the state output)
  localparam state_t S_IDLE  = 4'd0;
  localparam state_t S_T0    = 4'd1;
  localparam state_t S_T1    = 4'd2;
  localparam state_t S_T2    = 4'd3;
  localparam state_t S_T3    = 4'd4;
  localparam state_t S_T4    = 4'd5;
  localparam state_t S_T5    = 4'd6;
  localparam state_t S_HALT  = 4'd7;
  localparam state_t S_FAULT = 4'd8;

  // Supported immediate opcodes (IR[31:27])
  localparam logic [4:0] OPC_ADDI = 5'b01100;
  localparam logic [4:0] OPC_ANDI = 5'b01101;
  localparam logic [4:0] OPC_ORI  = 5'b01110;

  // ALU operation codes driven to the datapath
  localparam logic [4:0] ALU_NOP = 5'b00000;
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b01010;
  localparam logic [4:0] ALU_OR  = 5'b01011;

  // True while an instruction is being sequenced (T0..T5)
  function automatic logic in_sequence(input state_t s);
    return (s >= S_T0) && (s <= S_T5);
  endfunction

endpackage

// File: rtl/imm_op_decode.sv
// Combinational opcode decoder: maps an immediate opcode to its ALU
// operation and flags whether the opcode is one this unit can execute.
module imm_op_decode
  import imm_cu_pkg::*;
(
  input  logic [4:0] opcode_i,
  output logic       valid_o,
  output logic [4:0] ops_o
);

  // Opcode to ALU-operation lookup; unknown opcodes are flagged invalid
  always_comb begin
    valid_o = 1'b1;
    ops_o   = ALU_NOP;
    case (opcode_i)
      OPC_ADDI: ops_o = ALU_ADD;
      OPC_ANDI: ops_o = ALU_AND;
      OPC_ORI:  ops_o = ALU_OR;
      default: begin
        valid_o = 1'b0;
        ops_o   = ALU_NOP;
      end
    endcase
  end

endmodule

// File: rtl/imm_control_unit.sv
// Control unit sequencing fetch (T0..T2) and execute (T3..T5) of
// immediate ALU instructions. All outputs are a Moore decode of the
// registered state, the T1 wait counter and the latched ALU operation.
module imm_control_unit
  import imm_cu_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       run,
  input  logic       stop,
  input  logic [4:0] ir_opcode,
  input  logic       mem_ready,
  output logic       PCout,
  output logic       MARin,
  output logic       IncPC,
  output logic       RZin,
  output logic       RZLOout,
  output logic       PCin,
  output logic       Read,
  output logic       MDRin,
  output logic       MDRout,
  output logic       IRin,
  output logic       gra,
  output logic       grb,
  output logic       rin,
  output logic       rout,
  output logic       RYin,
  output logic       Cout,
  output logic [4:0] ops,
  output logic       busy,
  output logic       fault,
  output logic [3:0] state
);

  localparam int CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  // Counter value that, incremented once more, reaches the timeout limit
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);
  localparam logic [CW-1:0] WAIT_ZERO = CW'(0);
  localparam logic [CW-1:0] WAIT_ONE  = CW'(1);

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic [4:0]      ops_q, ops_d;
  logic            dec_valid_s;
  logic [4:0]      dec_ops_s;

  imm_op_decode u_dec (
    .opcode_i (ir_opcode),
    .valid_o  (dec_valid_s),
    .ops_o    (dec_ops_s)
  );

  // Next-state, wait-counter and ALU-operation latch logic
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ops_d   = ops_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_T0;
        else     state_d = S_IDLE;
      end
      S_T0: begin
        state_d = S_T1;
        wait_d  = WAIT_ZERO;
      end
      S_T1: begin
        if (mem_ready) begin
          state_d = S_T2;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
          wait_d  = wait_q + WAIT_ONE;
        end else begin
          wait_d  = wait_q + WAIT_ONE;
        end
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (dec_valid_s) begin
          state_d = S_T4;
          ops_d   = dec_ops_s;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        if (stop)     state_d = S_HALT;
        else if (run) state_d = S_T0;
        else          state_d = S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // State registers with synchronous active-low clear
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= S_IDLE;
      wait_q  <= WAIT_ZERO;
      ops_q   <= ALU_NOP;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ops_q   <= ops_d;
    end
  end

  // Moore output decode; each state drives at most one bus source
  always_comb begin
    PCout   = 1'b0;  MARin = 1'b0;  IncPC = 1'b0;  RZin  = 1'b0;
    RZLOout = 1'b0;  PCin  = 1'b0;  Read  = 1'b0;  MDRin = 1'b0;
    MDRout  = 1'b0;  IRin  = 1'b0;  gra   = 1'b0;  grb   = 1'b0;
    rin     = 1'b0;  rout  = 1'b0;  RYin  = 1'b0;  Cout  = 1'b0;
    case (state_q)
      S_T0: begin
        PCout = 1'b1;  MARin = 1'b1;  IncPC = 1'b1;  RZin = 1'b1;
      end
      S_T1: begin
        RZLOout = 1'b1;  Read = 1'b1;  MDRin = 1'b1;
        // PC reload only on the first T1 cycle, before any wait
        if (wait_q == WAIT_ZERO) PCin = 1'b1;
        else                     PCin = 1'b0;
      end
      S_T2: begin
        MDRout = 1'b1;  IRin = 1'b1;
      end
      S_T3: begin
        grb = 1'b1;  rout = 1'b1;  RYin = 1'b1;
      end
      S_T4: begin
        Cout = 1'b1;  RZin = 1'b1;
      end
      S_T5: begin
        RZLOout = 1'b1;  gra = 1'b1;  rin = 1'b1;
      end
      default: begin
        PCout = 1'b0;
      end
    endcase
  end

  // Status outputs and ALU operation, visible only while executing
  always_comb begin
    if ((state_q == S_T4) || (state_q == S_T5)) ops = ops_q;
    else                                         ops = ALU_NOP;
    busy  = in_sequence(state_q);
    fault = (state_q == S_FAULT);
    state = state_q;
  end

endmodule
